// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MULT/DIV engine: shift-add multiply, restoring divide, HI/LO write strobes, div0 pulse.
// Optional MULDIV_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are all zero.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             hi_we,
    output logic             lo_we,
    output logic             div0
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] MUL_RUN = 3'd1;
    localparam logic [2:0] DIV_RUN = 3'd2;
    localparam logic [2:0] FIXUP   = 3'd3;
    localparam logic [2:0] FINISH  = 3'd4;

    logic [2:0]         state;
    logic [CW-1:0]      counter;
    // mult: acc = partial product, mcand = shifted multiplicand, shreg = remaining multiplier
    // div:  acc = partial remainder, mcand = divisor, shreg = dividend shifting into quotient
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   shreg;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               div0_pend;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               mul_last;

    assign abs_a = op_a[WIDTH-1] ? -op_a : op_a;
    assign abs_b = op_b[WIDTH-1] ? -op_b : op_b;

    // Top bit of trial is the borrow: set means the divisor did not fit.
    assign rem_shift = {acc[WIDTH-1:0], shreg[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, mcand[WIDTH-1:0]};

    assign prod_fix = neg_lo ? -acc : acc;
    assign quot_fix = neg_lo ? -shreg : shreg;
    assign rem_fix  = neg_hi ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

`ifdef MULDIV_EARLY_OUT_EN
    assign mul_last = (counter == LAST) || ((shreg >> 1) == '0);
`else
    assign mul_last = (counter == LAST);
`endif

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; every register, result outputs included, returns to zero so an aborted op leaves no trace.
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            acc       <= '0;
            mcand     <= '0;
            shreg     <= '0;
            is_div    <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            div0_pend <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi_we     <= 1'b0;
            lo_we     <= 1'b0;
            div0      <= 1'b0;
            hi_out    <= '0;
            lo_out    <= '0;
        end else begin
            done  <= 1'b0;
            hi_we <= 1'b0;
            lo_we <= 1'b0;
            div0  <= 1'b0;
            if (done) busy <= 1'b0;

            case (state)
                IDLE: begin
                    // busy is still high during the done cycle, so a start there is dropped.
                    if (!busy && start_mult) begin
                        busy      <= 1'b1;
                        state     <= MUL_RUN;
                        counter   <= '0;
                        acc       <= '0;
                        mcand     <= {{WIDTH{1'b0}}, abs_a};
                        shreg     <= abs_b;
                        is_div    <= 1'b0;
                        neg_lo    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        neg_hi    <= 1'b0;
                        div0_pend <= 1'b0;
                    end else if (!busy && start_div) begin
                        busy      <= 1'b1;
                        counter   <= '0;
                        acc       <= '0;
                        mcand     <= {{WIDTH{1'b0}}, abs_b};
                        shreg     <= abs_a;
                        is_div    <= 1'b1;
                        neg_lo    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        neg_hi    <= op_a[WIDTH-1];
                        div0_pend <= (op_b == '0);
                        state     <= (op_b == '0) ? FINISH : DIV_RUN;
                    end
                end
                MUL_RUN: begin
                    if (shreg[0]) acc <= acc + mcand;
                    mcand   <= mcand << 1;
                    shreg   <= shreg >> 1;
                    counter <= counter + 1'b1;
                    if (mul_last) state <= FIXUP;
                end
                DIV_RUN: begin
                    acc     <= {{WIDTH{1'b0}}, (trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0])};
                    shreg   <= {shreg[WIDTH-2:0], ~trial[WIDTH]};
                    counter <= counter + 1'b1;
                    if (counter == LAST) state <= FIXUP;
                end
                FIXUP: begin
                    if (is_div) begin
                        hi_out <= rem_fix;
                        lo_out <= quot_fix;
                    end else begin
                        hi_out <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_out <= prod_fix[WIDTH-1:0];
                    end
                    state <= FINISH;
                end
                FINISH: begin
                    done  <= 1'b1;
                    hi_we <= ~div0_pend;
                    lo_we <= ~div0_pend;
                    div0  <= div0_pend;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: arithmetic/latency model plus directed literal vectors.
module tb_muldiv_sequencer;

    localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start_mult = 1'b0;
    logic         start_div = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy, done, hi_we, lo_we, div0;
    logic [W-1:0] hi_out, lo_out;

    int total = 0;
    int bad = 0;
    bit model_live = 1'b0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .hi_out(hi_out), .lo_out(lo_out), .hi_we(hi_we), .lo_we(lo_we), .div0(div0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {HI, LO} from plain signed 64-bit arithmetic.
    function automatic logic [63:0] model_result(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mult) return 64'(sa * sb);
        if (sb == 0) return '0;
        q = sa / sb;
        r = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Edges from acceptance until done rises.
    function automatic int op_latency(input bit is_mult, input logic [31:0] b);
        logic [31:0] mag;
        int n;
        if (!is_mult) return (b == 0) ? 1 : W + 2;
        if (!EARLY) return W + 2;
        mag = b[31] ? -b : b;
        n = 1;
        for (int i = 0; i < W; i++) if (mag[i]) n = i + 1;
        return n + 2;
    endfunction

    logic         m_busy, m_done, m_we, m_div0;
    logic [W-1:0] m_hi, m_lo;
    logic [63:0]  p_res;
    bit           pending, p_is0;
    int           done_edge;
    int           edge_cnt = 0;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (reset) begin
            m_busy <= 0; m_done <= 0; m_we <= 0; m_div0 <= 0;
            m_hi <= '0; m_lo <= '0; pending <= 0; p_is0 <= 0;
        end else begin
            m_done <= 0; m_we <= 0; m_div0 <= 0;
            if (pending) begin
                if (edge_cnt == done_edge - 1 && !p_is0) begin
                    m_hi <= p_res[63:32];
                    m_lo <= p_res[31:0];
                end
                if (edge_cnt == done_edge) begin
                    m_done <= 1; m_we <= !p_is0; m_div0 <= p_is0;
                end
                if (edge_cnt == done_edge + 1) begin
                    pending <= 0; m_busy <= 0;
                end
            end else if (start_mult || start_div) begin
                pending   <= 1;
                m_busy    <= 1;
                p_is0     <= !start_mult && (op_b == 0);
                p_res     <= model_result(start_mult, op_a, op_b);
                done_edge <= edge_cnt + op_latency(start_mult, op_b);
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("ctrl{busy,done,hi_we,lo_we,div0}", {busy, done, hi_we, lo_we, div0},
                  {m_busy, m_done, m_we, m_we, m_div0});
            check("hi_out", hi_out, m_hi);
            check("lo_out", lo_out, m_lo);
        end
    end

    task automatic run_op(input string tag, input bit do_mult, input bit do_div,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_lat, input bit exp_div0, input int poke);
        int k;
        @(posedge clk); #1;
        start_mult = do_mult; start_div = do_div; op_a = a; op_b = b;
        @(posedge clk); #1;
        start_mult = 0; start_div = 0; op_a = 32'hDEAD_BEEF; op_b = '0;
        k = 0;
        while (k < 100) begin
            @(posedge clk); #1;
            start_div = 0;
            k++;
            @(negedge clk);
            if (done) break;
            if (k == poke) start_div = 1;
        end
        check({tag, " latency"}, 64'(k), 64'(exp_lat));
        check({tag, " hi"}, hi_out, exp_hi);
        check({tag, " lo"}, lo_out, exp_lo);
        check({tag, " we"}, {hi_we, lo_we}, exp_div0 ? 2'b00 : 2'b11);
        check({tag, " div0"}, div0, exp_div0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        model_live = 1;
        #1 reset = 0;
        @(negedge clk);
        check("reset ctrl", {busy, done, hi_we, lo_we, div0}, 5'b0);
        check("reset hi/lo", {hi_out, lo_out}, 64'h0);

        run_op("mul 3*-5", 1, 0, 32'd3, -32'sd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, EARLY ? 5 : 34, 0, -1);
        run_op("div -7/2", 0, 1, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 0, -1);
        run_op("div 7/-2", 0, 1, 32'd7, -32'sd2, 32'h0000_0001, 32'hFFFF_FFFD, 34, 0, -1);
        run_op("div 5/0", 0, 1, 32'd5, 32'd0, 32'h0000_0001, 32'hFFFF_FFFD, 1, 1, -1);
        @(negedge clk);
        check("div0 busy after", busy, 1'b0);

        run_op("both 6,7", 1, 1, 32'd6, 32'd7, 32'h0, 32'd42, EARLY ? 5 : 34, 0, 2);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n++;
        end
        check("single done", 64'(n), 64'd0);

        run_op("mul min*-1", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, EARLY ? 3 : 34, 0, -1);
        run_op("div min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34, 0, -1);
        run_op("mul -1*-1", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, EARLY ? 3 : 34, 0, -1);
        run_op("mul max*max", 1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, EARLY ? 33 : 34, 0, -1);
        run_op("mul 5*1", 1, 0, 32'd5, 32'd1, 32'h0, 32'd5, EARLY ? 3 : 34, 0, -1);
        run_op("div 100/7", 0, 1, 32'd100, 32'd7, 32'd2, 32'd14, 34, 0, -1);
        run_op("div -100/-7", 0, 1, -32'sd100, -32'sd7, 32'hFFFF_FFFE, 32'd14, 34, 0, -1);

        // Abort a multiply partway through with reset.
        @(posedge clk); #1;
        start_mult = 1; op_a = 32'd9; op_b = 32'h7FFF_FFFF;
        @(posedge clk); #1;
        start_mult = 0;
        repeat (10) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        check("abort ctrl", {busy, done, hi_we, lo_we, div0}, 5'b0);
        check("abort hi/lo", {hi_out, lo_out}, 64'h0);
        run_op("mul after reset", 1, 0, 32'd3, -32'sd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, EARLY ? 5 : 34, 0, -1);
        run_op("mul 9*max", 1, 0, 32'd9, 32'h7FFF_FFFF, 32'h0000_0004, 32'h7FFF_FFF7, EARLY ? 33 : 34, 0, -1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
